// File: rtl/forwarding_control_unit.sv
// rtl/forwarding_control_unit.sv - EX-stage operand bypass selector with saturating MEM/WB hit counters
module forwarding_control_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [1:0]            WB_FORWARD_EN,
    input  logic [1:0]            MEM_FORWARD_EN,
    input  logic [DATA_WIDTH-1:0] WB_RD_DATA,
    input  logic [DATA_WIDTH-1:0] MEM_RD_DATA,
    output logic                  OUT1_FORWARD_EN,
    output logic                  OUT2_FORWARD_EN,
    output logic [DATA_WIDTH-1:0] OUT1_FORWARD_DATA,
    output logic [DATA_WIDTH-1:0] OUT2_FORWARD_DATA,
    output logic [CNT_WIDTH-1:0]  MEM_HIT_COUNT,
    output logic [CNT_WIDTH-1:0]  WB_HIT_COUNT
);

    logic [1:0]           mem_sel;
    logic [1:0]           wb_sel;
    logic [1:0]           mem_inc;
    logic [1:0]           wb_inc;
    logic [CNT_WIDTH-1:0] mem_cnt_q, mem_cnt_d;
    logic [CNT_WIDTH-1:0] wb_cnt_q, wb_cnt_d;
    logic [CNT_WIDTH:0]   mem_sum;
    logic [CNT_WIDTH:0]   wb_sum;

    // MEM holds the younger producer, so it masks any WB enable for the same operand.
    always_comb begin
        mem_sel = MEM_FORWARD_EN;
        wb_sel  = WB_FORWARD_EN & ~MEM_FORWARD_EN;
    end

    always_comb begin
        OUT1_FORWARD_EN   = 1'b0;
        OUT1_FORWARD_DATA = '0;
        if (mem_sel[0]) begin
            OUT1_FORWARD_EN   = 1'b1;
            OUT1_FORWARD_DATA = MEM_RD_DATA;
        end else if (wb_sel[0]) begin
            OUT1_FORWARD_EN   = 1'b1;
            OUT1_FORWARD_DATA = WB_RD_DATA;
        end
    end

    always_comb begin
        OUT2_FORWARD_EN   = 1'b0;
        OUT2_FORWARD_DATA = '0;
        if (mem_sel[1]) begin
            OUT2_FORWARD_EN   = 1'b1;
            OUT2_FORWARD_DATA = MEM_RD_DATA;
        end else if (wb_sel[1]) begin
            OUT2_FORWARD_EN   = 1'b1;
            OUT2_FORWARD_DATA = WB_RD_DATA;
        end
    end

    // One extra sum bit catches overflow so an increment of 2 from max-1 clamps to max.
    always_comb begin
        mem_inc  = {1'b0, mem_sel[0]} + {1'b0, mem_sel[1]};
        wb_inc   = {1'b0, wb_sel[0]} + {1'b0, wb_sel[1]};
        mem_sum  = {1'b0, mem_cnt_q} + {{(CNT_WIDTH-1){1'b0}}, mem_inc};
        wb_sum   = {1'b0, wb_cnt_q} + {{(CNT_WIDTH-1){1'b0}}, wb_inc};
        mem_cnt_d = mem_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : mem_sum[CNT_WIDTH-1:0];
        wb_cnt_d  = wb_sum[CNT_WIDTH]  ? {CNT_WIDTH{1'b1}} : wb_sum[CNT_WIDTH-1:0];
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            mem_cnt_q <= '0;
            wb_cnt_q  <= '0;
        end else begin
            mem_cnt_q <= mem_cnt_d;
            wb_cnt_q  <= wb_cnt_d;
        end
    end

    assign MEM_HIT_COUNT = mem_cnt_q;
    assign WB_HIT_COUNT  = wb_cnt_q;

endmodule

// File: tb/tb_forwarding_control_unit.sv
// tb/tb_forwarding_control_unit.sv - directed self-checking bench for forwarding_control_unit
module tb_forwarding_control_unit;

    logic        clk;
    logic        resetn;
    logic [1:0]  wb_en;
    logic [1:0]  mem_en;
    logic [31:0] wb_data;
    logic [31:0] mem_data;

    logic        o1_en, o2_en;
    logic [31:0] o1_data, o2_data;
    logic [15:0] mem_cnt, wb_cnt;

    logic        s1_en, s2_en;
    logic [31:0] s1_data, s2_data;
    logic [3:0]  mem_cnt4, wb_cnt4;

    int n_cmp = 0;
    int n_err = 0;

    forwarding_control_unit dut (
        .CLK(clk), .RESET(resetn),
        .WB_FORWARD_EN(wb_en), .MEM_FORWARD_EN(mem_en),
        .WB_RD_DATA(wb_data), .MEM_RD_DATA(mem_data),
        .OUT1_FORWARD_EN(o1_en), .OUT2_FORWARD_EN(o2_en),
        .OUT1_FORWARD_DATA(o1_data), .OUT2_FORWARD_DATA(o2_data),
        .MEM_HIT_COUNT(mem_cnt), .WB_HIT_COUNT(wb_cnt)
    );

    forwarding_control_unit #(.DATA_WIDTH(32), .CNT_WIDTH(4)) dut4 (
        .CLK(clk), .RESET(resetn),
        .WB_FORWARD_EN(wb_en), .MEM_FORWARD_EN(mem_en),
        .WB_RD_DATA(wb_data), .MEM_RD_DATA(mem_data),
        .OUT1_FORWARD_EN(s1_en), .OUT2_FORWARD_EN(s2_en),
        .OUT1_FORWARD_DATA(s1_data), .OUT2_FORWARD_DATA(s2_data),
        .MEM_HIT_COUNT(mem_cnt4), .WB_HIT_COUNT(wb_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_ops(input string tag, input logic e1, input logic [31:0] d1,
                           input logic e2, input logic [31:0] d2);
        chk({tag, ".out1_en"},   {31'd0, o1_en}, {31'd0, e1});
        chk({tag, ".out1_data"}, o1_data, d1);
        chk({tag, ".out2_en"},   {31'd0, o2_en}, {31'd0, e2});
        chk({tag, ".out2_data"}, o2_data, d2);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] e_d1, e_d2;
    logic        e_e1, e_e2;

    initial begin
        resetn   = 1'b0;
        wb_en    = 2'b00;
        mem_en   = 2'b00;
        wb_data  = 32'hAAAA_AAAA;
        mem_data = 32'h5555_5555;

        // Forwarding checks run while reset is asserted: outputs must not be gated by it.
        #1;
        chk_ops("none", 1'b0, 32'h0, 1'b0, 32'h0);
        wb_en = 2'b00; mem_en = 2'b01; #1;
        chk_ops("mem_op1", 1'b1, 32'h5555_5555, 1'b0, 32'h0);
        wb_en = 2'b10; mem_en = 2'b00; #1;
        chk_ops("wb_op2", 1'b0, 32'h0, 1'b1, 32'hAAAA_AAAA);
        wb_en = 2'b11; mem_en = 2'b11; #1;
        chk_ops("both_mem", 1'b1, 32'h5555_5555, 1'b1, 32'h5555_5555);
        wb_en = 2'b11; mem_en = 2'b10; #1;
        chk_ops("split_a", 1'b1, 32'hAAAA_AAAA, 1'b1, 32'h5555_5555);
        wb_en = 2'b01; mem_en = 2'b10; #1;
        chk_ops("split_b", 1'b1, 32'hAAAA_AAAA, 1'b1, 32'h5555_5555);
        wb_en = 2'b11; mem_en = 2'b01; #1;
        chk_ops("ex_11_01", 1'b1, 32'h5555_5555, 1'b1, 32'hAAAA_AAAA);
        wb_en = 2'b10; mem_en = 2'b11; #1;
        chk_ops("ex_10_11", 1'b1, 32'h5555_5555, 1'b1, 32'h5555_5555);

        resetn = 1'b1;
        for (int c = 0; c < 16; c++) begin
            wb_en  = 2'(c >> 2);
            mem_en = 2'(c & 3);
            wb_data  = 32'h1000_0000 + 32'(c);
            mem_data = 32'h2000_0000 + 32'(c);
            case ({wb_en[0], mem_en[0]})
                2'b00:   begin e_e1 = 1'b0; e_d1 = 32'h0;    end
                2'b10:   begin e_e1 = 1'b1; e_d1 = wb_data;  end
                default: begin e_e1 = 1'b1; e_d1 = mem_data; end
            endcase
            case ({wb_en[1], mem_en[1]})
                2'b00:   begin e_e2 = 1'b0; e_d2 = 32'h0;    end
                2'b10:   begin e_e2 = 1'b1; e_d2 = wb_data;  end
                default: begin e_e2 = 1'b1; e_d2 = mem_data; end
            endcase
            #2;
            chk_ops($sformatf("sweep%0d", c), e_e1, e_d1, e_e2, e_d2);
            wb_data  = ~wb_data;
            mem_data = ~mem_data;
            if (e_d1 != 32'h0) e_d1 = ~e_d1;
            if (e_d2 != 32'h0) e_d2 = ~e_d2;
            #1;
            chk_ops($sformatf("sweep%0d_mid", c), e_e1, e_d1, e_e2, e_d2);
            #7;
        end

        wb_data  = 32'hAAAA_AAAA;
        mem_data = 32'h5555_5555;
        wb_en = 2'b00; mem_en = 2'b00;
        resetn = 1'b0;
        tick();
        tick();
        chk("rst_mem_cnt", {16'd0, mem_cnt}, 32'd0);
        chk("rst_wb_cnt",  {16'd0, wb_cnt},  32'd0);
        chk("rst_mem_cnt4", {28'd0, mem_cnt4}, 32'd0);

        resetn = 1'b1; wb_en = 2'b11; mem_en = 2'b01;
        tick(); tick(); tick();
        chk("cnt3_mem", {16'd0, mem_cnt}, 32'd3);
        chk("cnt3_wb",  {16'd0, wb_cnt},  32'd3);

        wb_en = 2'b11; mem_en = 2'b00;
        tick(); tick();
        chk("cnt_wb_dbl", {16'd0, wb_cnt},  32'd7);
        chk("cnt_mem_hold", {16'd0, mem_cnt}, 32'd3);

        wb_en = 2'b00; resetn = 1'b0;
        tick();
        chk("rerst_mem", {16'd0, mem_cnt}, 32'd0);
        chk("rerst_wb",  {16'd0, wb_cnt},  32'd0);

        resetn = 1'b1; wb_en = 2'b11; mem_en = 2'b11;
        for (int i = 0; i < 7; i++) tick();
        chk("sat_pre", {28'd0, mem_cnt4}, 32'd14);
        tick();
        chk("sat_clamp", {28'd0, mem_cnt4}, 32'd15);
        tick(); tick();
        chk("sat_hold", {28'd0, mem_cnt4}, 32'd15);
        chk("sat_wb_zero", {28'd0, wb_cnt4}, 32'd0);
        chk("wide_mem20", {16'd0, mem_cnt}, 32'd20);
        chk("wide_wb_zero", {16'd0, wb_cnt}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/forwarding_control_unit.md
Name: forwarding_control_unit

Overview:
- Operand-forwarding selector for the RV32IM 5-stage pipeline, sitting at the EX-stage operand inputs.
- Per-operand enables come from the hazard-detection logic, one pair for the MEM stage and one for the WB stage. From these, the block picks the bypass source for operand 1 (rs1) and operand 2 (rs2) and drives the forwarded data plus a forward-valid flag per operand.
- It also keeps saturating hit counters for performance visibility.

Parameters:
- DATA_WIDTH, 32, width of forwarded data words.
- CNT_WIDTH, 16, width of each statistics counter.

Ports:
- CLK  input  1  pipeline clock; counters update on rising edge.
- RESET  input  1  synchronous, active-low reset (0 = reset, sampled on rising CLK).
- WB_FORWARD_EN  input  2  bit0: WB result feeds operand 1; bit1: WB result feeds operand 2.
- MEM_FORWARD_EN  input  2  bit0: MEM result feeds operand 1; bit1: MEM result feeds operand 2.
- WB_RD_DATA  input  DATA_WIDTH  rd write-back value in WB stage.
- MEM_RD_DATA  input  DATA_WIDTH  rd result value in MEM stage.
- OUT1_FORWARD_EN  output  1  operand 1 takes OUT1_FORWARD_DATA instead of the register-file value.
- OUT2_FORWARD_EN  output  1  operand 2 takes OUT2_FORWARD_DATA instead of the register-file value.
- OUT1_FORWARD_DATA  output  DATA_WIDTH  forwarded value for operand 1.
- OUT2_FORWARD_DATA  output  DATA_WIDTH  forwarded value for operand 2.
- MEM_HIT_COUNT  output  CNT_WIDTH  count of operand forwards served from MEM.
- WB_HIT_COUNT  output  CNT_WIDTH  count of operand forwards served from WB.

Behaviour:
- Forwarding path is purely combinational, zero latency. Outputs follow inputs within the same cycle, with no dependence on CLK.
- Operand n (n=1 uses bit0, n=2 uses bit1) is resolved independently:
  - MEM_FORWARD_EN[n] = 1: OUTn_FORWARD_EN = 1, OUTn_FORWARD_DATA = MEM_RD_DATA. MEM has priority because it holds the younger instruction.
  - Else WB_FORWARD_EN[n] = 1: OUTn_FORWARD_EN = 1, OUTn_FORWARD_DATA = WB_RD_DATA.
  - Else: OUTn_FORWARD_EN = 0, OUTn_FORWARD_DATA = all zeros (no stale data).
- Both operands may select the same source or different sources in the same cycle. All 16 enable combinations are legal.
- Priority examples:
  - WB=11, MEM=01: operand 1 <- MEM, operand 2 <- WB.
  - WB=10, MEM=11: both operands <- MEM.
- RESET level does not gate the combinational forwarding outputs; they remain valid during reset.
- Counters, updated each rising CLK edge:
  - If RESET == 0, both counters load 0.
  - Otherwise MEM_HIT_COUNT += number of operands sourced from MEM this cycle (0, 1 or 2).
  - WB_HIT_COUNT += number of operands sourced from WB this cycle (0, 1 or 2). A WB enable overridden by MEM does not count.
  - Counters saturate at all-ones: no wrap, and an increment of 2 from max-1 yields max.
- Counter reset values are 0. Counters are X-free after the first reset edge.
- X on an enable bit may propagate to the corresponding outputs; no X-masking is required.

Test Plan:
- WB_RD_DATA=0xAAAAAAAA, MEM_RD_DATA=0x55555555, WB=00, MEM=00 -> both EN=0, both DATA=0x00000000.
- WB=00, MEM=01 -> OUT1_EN=1, OUT1_DATA=0x55555555; OUT2_EN=0, OUT2_DATA=0. WB=10, MEM=00 -> OUT2_EN=1, OUT2_DATA=0xAAAAAAAA; OUT1_EN=0.
- Priority: WB=11, MEM=11 -> both DATA=0x55555555. WB=11, MEM=10 -> OUT1=0xAAAAAAAA, OUT2=0x55555555. WB=01, MEM=10 -> OUT1=0xAAAAAAAA, OUT2=0x55555555.
- Exhaustive sweep of all 16 (WB, MEM) combinations with 10 ns steps -> every output matches the priority rule above; check changes of data inputs mid-step propagate immediately.
- Counters: hold RESET=0 for 2 clocks -> both counts 0. Release, then apply WB=11, MEM=01 for 3 clocks -> MEM_HIT_COUNT=3, WB_HIT_COUNT=3. Assert RESET=0 for one edge -> both counts 0 on that edge.
- Saturation with CNT_WIDTH=4: drive MEM=11 for 10 clocks after reset -> MEM_HIT_COUNT sticks at 15; WB_HIT_COUNT stays 0 with WB=11 overridden.
